// File: rtl/gpu_pixel_burst_writer.sv
// Pixel burst writer: merges multi-lane pixel beats into a per-segment fill buffer
// and hands completed or flushed segments to a single output register.
module gpu_pixel_burst_writer #(
  parameter int LANES     = 2,
  parameter int BURST_PIX = 8
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_inValid,
  output logic                   o_inReady,
  input  logic [9:0]             i_scrX,
  input  logic [8:0]             i_scrY,
  input  logic [16*LANES-1:0]    i_pixel,
  input  logic [LANES-1:0]       i_pixValid,
  input  logic                   i_forceMask,
  input  logic                   i_flush,
  output logic                   o_burstReq,
  input  logic                   i_burstAck,
  output logic [9:0]             o_burstX,
  output logic [8:0]             o_burstY,
  output logic [16*BURST_PIX-1:0] o_burstData,
  output logic [BURST_PIX-1:0]   o_burstEn,
  output logic                   o_idle
);

  localparam int SB = $clog2(BURST_PIX);
  localparam int SW = 10 - SB;

  logic [SW-1:0]            fillSegReg;
  logic [8:0]               fillYReg;
  logic [16*BURST_PIX-1:0]  fillDataReg;
  logic [BURST_PIX-1:0]     fillEnReg;
  logic                     flushPendingReg;
  logic                     outValidReg;
  logic [SW-1:0]            outSegReg;
  logic [8:0]               outYReg;
  logic [16*BURST_PIX-1:0]  outDataReg;
  logic [BURST_PIX-1:0]     outEnReg;

  logic [SW-1:0]            beatSeg;
  logic [SB-1:0]            beatSlot;
  logic                     beatAny, fillBusy, miss, endSeg, outFree, accept;
  logic                     evictOld, evictMerged, evict, fillEmptyNext, flushPendingNext;
  logic [16*BURST_PIX-1:0]  mergedData;
  logic [BURST_PIX-1:0]     mergedEn;

  assign beatSeg  = i_scrX[9:SB];
  assign beatSlot = i_scrX[SB-1:0];
  assign beatAny  = |i_pixValid;
  assign fillBusy = |fillEnReg;
  assign miss     = beatAny && fillBusy && ((beatSeg != fillSegReg) || (i_scrY != fillYReg));
  assign endSeg   = beatAny && ((int'(beatSlot) + LANES) == BURST_PIX);
  assign outFree  = !outValidReg || i_burstAck;
  assign o_inReady = !i_rst && (outFree || !(miss || endSeg));
  assign accept   = i_inValid && o_inReady;

  // Fill contents as they would look after this cycle's beat, before any eviction.
  always_comb begin
    mergedData = (accept && miss) ? '0 : fillDataReg;
    mergedEn   = (accept && miss) ? '0 : fillEnReg;
    for (int k = 0; k < LANES; k++) begin
      if (accept && i_pixValid[k]) begin
        mergedData[16*(int'(beatSlot)+k) +: 16] =
          {i_pixel[16*k+15] | i_forceMask, i_pixel[16*k +: 15]};
        mergedEn[int'(beatSlot)+k] = 1'b1;
      end
    end
  end

  // A miss that also ends its segment evicts the old fill now and the new one via the flush path.
  assign evictOld      = accept && miss;
  assign evictMerged   = !evictOld && ((accept && endSeg) ||
                                       (flushPendingReg && (|mergedEn) && outFree));
  assign evict         = evictOld || evictMerged;
  assign fillEmptyNext = evictMerged || !(|mergedEn);
  assign flushPendingNext = (i_flush || (evictOld && endSeg) || (flushPendingReg && !evict))
                            && !fillEmptyNext;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      fillSegReg      <= '0;
      fillYReg        <= '0;
      fillDataReg     <= '0;
      fillEnReg       <= '0;
      flushPendingReg <= 1'b0;
      outValidReg     <= 1'b0;
      outSegReg       <= '0;
      outYReg         <= '0;
      outDataReg      <= '0;
      outEnReg        <= '0;
    end else begin
      if (evictMerged) begin
        fillDataReg <= '0;
        fillEnReg   <= '0;
      end else if (accept && beatAny) begin
        fillDataReg <= mergedData;
        fillEnReg   <= mergedEn;
        fillSegReg  <= beatSeg;
        fillYReg    <= i_scrY;
      end

      if (evictOld) begin
        outValidReg <= 1'b1;
        outSegReg   <= fillSegReg;
        outYReg     <= fillYReg;
        outDataReg  <= fillDataReg;
        outEnReg    <= fillEnReg;
      end else if (evictMerged) begin
        outValidReg <= 1'b1;
        outSegReg   <= (accept && beatAny) ? beatSeg : fillSegReg;
        outYReg     <= (accept && beatAny) ? i_scrY : fillYReg;
        outDataReg  <= mergedData;
        outEnReg    <= mergedEn;
      end else if (i_burstAck) begin
        outValidReg <= 1'b0;
      end

      flushPendingReg <= flushPendingNext;
    end
  end

  // Reset blanks the outputs immediately, not just from the next edge.
  assign o_burstReq  = outValidReg && !i_rst;
  assign o_burstX    = i_rst ? '0 : {outSegReg, {SB{1'b0}}};
  assign o_burstY    = i_rst ? '0 : outYReg;
  assign o_burstData = i_rst ? '0 : outDataReg;
  assign o_burstEn   = i_rst ? '0 : outEnReg;
  assign o_idle      = !i_rst && !outValidReg && !fillBusy && !flushPendingReg;

endmodule

// File: tb/tb_gpu_pixel_burst_writer.sv
// Bench for gpu_pixel_burst_writer (LANES=2, BURST_PIX=8): directed scenarios plus
// random traffic against a per-segment pixel model.
module tb_gpu_pixel_burst_writer;
  localparam int L  = 2;
  localparam int BP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst = 1'b1, i_inValid = 1'b0, o_inReady;
  logic [9:0]      i_scrX = '0;
  logic [8:0]      i_scrY = '0;
  logic [16*L-1:0] i_pixel = '0;
  logic [L-1:0]    i_pixValid = '0;
  logic            i_forceMask = 1'b0, i_flush = 1'b0, o_burstReq, i_burstAck = 1'b0;
  logic [9:0]      o_burstX;
  logic [8:0]      o_burstY;
  logic [16*BP-1:0] o_burstData;
  logic [BP-1:0]   o_burstEn;
  logic            o_idle;

  int checks = 0;
  int errors = 0;

  gpu_pixel_burst_writer #(.LANES(L), .BURST_PIX(BP)) dut (
    .clk(clk), .i_rst(i_rst), .i_inValid(i_inValid), .o_inReady(o_inReady),
    .i_scrX(i_scrX), .i_scrY(i_scrY), .i_pixel(i_pixel), .i_pixValid(i_pixValid),
    .i_forceMask(i_forceMask), .i_flush(i_flush), .o_burstReq(o_burstReq),
    .i_burstAck(i_burstAck), .o_burstX(o_burstX), .o_burstY(o_burstY),
    .o_burstData(o_burstData), .o_burstEn(o_burstEn), .o_idle(o_idle));

  // Reference model: one pending segment of pixels and one finished burst.
  bit          mOutValid, mFlush;
  int          mOutX, mOutY, mFillX, mFillY;
  logic [15:0] mOutPix[BP], mFillPix[BP];
  bit          mOutEn[BP], mFillEn[BP];

  function automatic int fillCount();
    int n = 0;
    for (int s = 0; s < BP; s++) n += int'(mFillEn[s]);
    return n;
  endfunction

  function automatic bit modelReady();
    int  base = int'(i_scrX) - int'(i_scrX) % BP;
    bit  any = |i_pixValid;
    bit  wouldEvict = any && ((fillCount() > 0 && (base != mFillX || int'(i_scrY) != mFillY))
                              || (int'(i_scrX) % BP + L == BP));
    if (i_rst) return 1'b0;
    return !wouldEvict || !mOutValid || i_burstAck;
  endfunction

  function automatic bit modelIdle();
    return !i_rst && !mOutValid && fillCount() == 0 && !mFlush;
  endfunction

  function automatic logic [16*BP-1:0] expData();
    logic [16*BP-1:0] d;
    for (int s = 0; s < BP; s++) d[16*s +: 16] = mOutPix[s];
    return d;
  endfunction

  function automatic logic [BP-1:0] expEn();
    logic [BP-1:0] e;
    for (int s = 0; s < BP; s++) e[s] = mOutEn[s];
    return e;
  endfunction

  task automatic moveFillToOut();
    mOutValid = 1'b1;
    mOutX = mFillX;
    mOutY = mFillY;
    for (int s = 0; s < BP; s++) begin
      mOutPix[s] = mFillPix[s]; mOutEn[s] = mFillEn[s];
      mFillPix[s] = '0; mFillEn[s] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    bit canOut, rdy, evicted, extra;
    int base, slot;
    logic [15:0] p;
    if (i_rst) begin
      mOutValid = 0; mFlush = 0; mOutX = 0; mOutY = 0; mFillX = 0; mFillY = 0;
      for (int s = 0; s < BP; s++) begin
        mOutPix[s] = '0; mOutEn[s] = 0; mFillPix[s] = '0; mFillEn[s] = 0;
      end
      return;
    end
    canOut = !mOutValid || i_burstAck;
    rdy = modelReady();
    evicted = 0; extra = 0;
    if (mOutValid && i_burstAck) mOutValid = 0;
    if (i_inValid && rdy && |i_pixValid) begin
      base = int'(i_scrX) - int'(i_scrX) % BP;
      slot = int'(i_scrX) % BP;
      if (fillCount() > 0 && (base != mFillX || int'(i_scrY) != mFillY)) begin
        moveFillToOut(); evicted = 1; extra = (slot + L == BP);
      end
      mFillX = base; mFillY = int'(i_scrY);
      for (int k = 0; k < L; k++) if (i_pixValid[k]) begin
        p = i_pixel[16*k +: 16];
        p[15] = p[15] | i_forceMask;
        mFillPix[slot+k] = p; mFillEn[slot+k] = 1'b1;
      end
      if (!evicted && slot + L == BP) begin moveFillToOut(); evicted = 1; end
    end
    if (!evicted && mFlush && fillCount() > 0 && canOut) begin moveFillToOut(); evicted = 1; end
    if (evicted) mFlush = 0;
    if (i_flush || extra) mFlush = 1;
    if (fillCount() == 0) mFlush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic quiet();
    i_inValid = 0; i_pixValid = '0; i_flush = 0; i_forceMask = 0;
  endtask

  task automatic beat(input int x, input int y, input logic [L-1:0] v, input logic [16*L-1:0] pix);
    i_inValid = 1; i_scrX = 10'(x); i_scrY = 9'(y); i_pixValid = v; i_pixel = pix;
    tick();
    i_inValid = 0; i_pixValid = '0;
  endtask

  task automatic drain();
    int n = 0;
    quiet(); i_flush = 1; tick(); i_flush = 0; i_burstAck = 1;
    while (!o_idle && n < 20) begin tick(); n++; end
    checks++;
    if (o_idle !== 1'b1) begin errors++; $display("FAIL drain_idle got %b want 1", o_idle); end
    i_burstAck = 0;
  endtask

  task automatic test_reset();
    quiet(); i_rst = 1; tick(); tick(); tick();
    checks++;
    if ({o_burstReq, o_inReady, o_idle, o_burstEn} !== '0) begin
      errors++; $display("FAIL reset_outputs got req=%b rdy=%b idle=%b en=%h want 0", o_burstReq, o_inReady, o_idle, o_burstEn);
    end
    i_rst = 0; #1;
    checks++;
    if (o_inReady !== 1'b1 || o_idle !== 1'b1) begin
      errors++; $display("FAIL reset_release got rdy=%b idle=%b want 1 1", o_inReady, o_idle);
    end
  endtask

  task automatic test_full_segment();
    i_burstAck = 1;
    for (int i = 0; i < 4; i++) beat(2*i, 5, 2'b11, {16'(16'h0100 + 2*i + 1), 16'(16'h0100 + 2*i)});
    checks++;
    if (o_burstReq !== 1'b1 || o_burstX !== 10'd0 || o_burstY !== 9'd5 || o_burstEn !== 8'hFF
        || o_burstData !== expData()) begin
      errors++; $display("FAIL full_segment got req=%b x=%0d y=%0d en=%h data=%h want 1 0 5 ff %h",
                         o_burstReq, o_burstX, o_burstY, o_burstEn, o_burstData, expData());
    end
    tick();
    checks++;
    if (o_burstReq !== 1'b0) begin errors++; $display("FAIL full_segment_once got req=%b want 0", o_burstReq); end
    i_burstAck = 0;
  endtask

  task automatic test_miss();
    beat(0, 1, 2'b11, 32'hAAAA_5555);
    beat(8, 1, 2'b11, 32'h1111_2222);
    checks++;
    if (o_burstReq !== 1'b1 || o_burstX !== 10'd0 || o_burstEn !== 8'h03 || o_idle !== 1'b0
        || o_burstData[31:0] !== 32'hAAAA_5555) begin
      errors++; $display("FAIL miss got req=%b x=%0d en=%h idle=%b d=%h want 1 0 03 0 aaaa5555",
                         o_burstReq, o_burstX, o_burstEn, o_idle, o_burstData[31:0]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) beat(2*i, 2, 2'b11, 32'h0F0F_F0F0);
    beat(0, 3, 2'b01, 32'h0000_0333);
    i_inValid = 1; i_scrX = 10'd0; i_scrY = 9'd4; i_pixValid = 2'b11; i_pixel = 32'h4444_4444;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_inReady !== 1'b0 || o_burstY !== 9'd2) begin
        errors++; $display("FAIL stall got rdy=%b y=%0d want 0 2", o_inReady, o_burstY);
      end
      tick();
    end
    i_burstAck = 1; #1;
    checks++;
    if (o_inReady !== 1'b1) begin errors++; $display("FAIL stall_release got rdy=%b want 1", o_inReady); end
    tick();
    i_inValid = 0; i_pixValid = '0; i_burstAck = 0;
    checks++;
    if (o_burstReq !== 1'b1 || o_burstY !== 9'd3 || o_burstEn !== 8'h01 || o_burstData[15:0] !== 16'h0333) begin
      errors++; $display("FAIL next_burst got req=%b y=%0d en=%h d=%h want 1 3 01 0333",
                         o_burstReq, o_burstY, o_burstEn, o_burstData[15:0]);
    end
    drain();
  endtask

  task automatic test_force_mask();
    i_forceMask = 1;
    beat(0, 7, 2'b01, 32'h0000_1234);
    i_forceMask = 0; i_flush = 1; tick(); i_flush = 0; tick();
    checks++;
    if (o_burstReq !== 1'b1 || o_burstData[15:0] !== 16'h9234 || o_burstEn !== 8'h01) begin
      errors++; $display("FAIL force_mask got req=%b d=%h en=%h want 1 9234 01", o_burstReq, o_burstData[15:0], o_burstEn);
    end
    drain();
  endtask

  task automatic test_partial_flush();
    beat(2, 9, 2'b10, 32'h7FFF_0000);
    i_flush = 1; tick(); i_flush = 0; tick();
    checks++;
    if (o_burstReq !== 1'b1 || o_burstEn !== 8'h08 || o_burstData[63:48] !== 16'h7FFF) begin
      errors++; $display("FAIL partial_flush got req=%b en=%h s3=%h want 1 08 7fff", o_burstReq, o_burstEn, o_burstData[63:48]);
    end
    i_burstAck = 1; tick(); i_burstAck = 0;
    i_flush = 1; tick(); i_flush = 0; tick(); tick();
    checks++;
    if (o_burstReq !== 1'b0 || o_idle !== 1'b1) begin
      errors++; $display("FAIL empty_flush got req=%b idle=%b want 0 1", o_burstReq, o_idle);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4; i++) beat(2*i, 6, 2'b11, 32'h1357_2468);
    beat(0, 8, 2'b11, 32'h1111_1111);
    i_rst = 1; #1;
    checks++;
    if (o_burstReq !== 1'b0) begin errors++; $display("FAIL reset_mid got req=%b want 0", o_burstReq); end
    tick(); i_rst = 0; #1;
    tick();
    checks++;
    if (o_idle !== 1'b1 || o_burstReq !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after got idle=%b req=%b want 1 0", o_idle, o_burstReq);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      i_inValid   = ($urandom_range(0, 9) < 7);
      i_scrX      = 10'($urandom_range(0, 1) * BP + $urandom_range(0, BP/L - 1) * L);
      i_scrY      = 9'($urandom_range(0, 1));
      i_pixValid  = L'($urandom);
      i_pixel     = 32'($urandom);
      i_forceMask = ($urandom_range(0, 3) == 0);
      i_flush     = ($urandom_range(0, 9) == 0);
      i_burstAck  = ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (o_inReady !== modelReady() || o_burstReq !== mOutValid || o_idle !== modelIdle()) begin
        errors++; $display("FAIL rand_ctrl cyc %0d got rdy=%b req=%b idle=%b want %b %b %b",
                           c, o_inReady, o_burstReq, o_idle, modelReady(), mOutValid, modelIdle());
      end
      if (mOutValid) begin
        checks++;
        if (o_burstX !== 10'(mOutX) || o_burstY !== 9'(mOutY) || o_burstEn !== expEn()
            || o_burstData !== expData()) begin
          errors++; $display("FAIL rand_burst cyc %0d got x=%0d y=%0d en=%h d=%h want %0d %0d %h %h",
                             c, o_burstX, o_burstY, o_burstEn, o_burstData, mOutX, mOutY, expEn(), expData());
        end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_full_segment();
    test_miss();
    test_back_to_back();
    test_force_mask();
    test_partial_flush();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
